// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store alignment controller.
// Build option: LSU_MISALIGN_SPLIT_EN adds the second access state for word-crossing accesses.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
`ifdef LSU_MISALIGN_SPLIT_EN
    ACC1,
`endif
    RESP
  } lsu_state_e;

  // Access size in bytes; 0 marks an encoding with no defined size.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      F3_W:        size_of = 3'd4;
      default:     size_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Picks the byte/half/word out of a right-aligned raw load value and
// sign- or zero-extends it to 32 bits according to funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   data = {24'd0, raw[7:0]};
      F3_HU:   data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller in front of a byte-addressed data memory.
// Build option: LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two memory cycles.
module lsu_align_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int SPAN = 8;
`else
  localparam int SPAN = 4;
`endif

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // The request being decoded: live inputs while IDLE, the latched copy afterwards.
  logic              cur_we;
  logic [2:0]        cur_f3;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;

  logic [2:0]        cur_size;
  logic [1:0]        cur_off;
  logic              cur_cross;
  logic              f3_bad;
  logic              out_of_range;
  logic              misaligned;
  logic              req_bad;
  logic [ADDR_W:0]   last_byte;
  logic [31:0]       word_addr;
  logic [3:0]        size_mask;
  logic [SPAN-1:0]   lane_be;
  logic [8*SPAN-1:0] lane_wd;

  logic [31:0]       lo_bytes;
  logic [31:0]       raw_sel;
  logic [31:0]       ext_data;

  assign cur_we    = (state_q == IDLE) ? req_we     : we_q;
  assign cur_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;

  always_comb begin
    cur_size  = size_of(cur_f3);
    cur_off   = cur_addr[1:0];
    cur_cross = ({1'b0, cur_off} + cur_size) > 3'd4;

    case (cur_f3)
      F3_B, F3_H, F3_W: f3_bad = 1'b0;
      F3_BU, F3_HU:     f3_bad = cur_we;
      default:          f3_bad = 1'b1;
    endcase

    // One extra bit so an access near the top of the address space cannot wrap to 0.
    last_byte    = {1'b0, cur_addr} + (ADDR_W+1)'(cur_size) - (ADDR_W+1)'(1);
    out_of_range = last_byte >= (ADDR_W+1)'(MEM_BYTES);

`ifdef LSU_MISALIGN_SPLIT_EN
    misaligned = 1'b0;
`else
    misaligned = cur_cross || ((cur_size == 3'd2) && cur_off[0]) ||
                 ((cur_size == 3'd4) && (cur_off != 2'd0));
`endif
    req_bad = f3_bad || out_of_range || misaligned;

    word_addr = 32'({cur_addr[ADDR_W-1:2], 2'b00});
    case (cur_size)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_be = SPAN'(size_mask) << cur_off;
    lane_wd = (8*SPAN)'(cur_wdata) << {cur_off, 3'b000};
  end

  // Load data: bytes from the first word land right-aligned; the second word fills above them.
  assign lo_bytes = mem_rdata >> {cur_off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] raw_q, raw_d;
  logic [31:0] hi_bytes;

  assign hi_bytes = mem_rdata << {3'd4 - {1'b0, cur_off}, 3'b000};
  assign raw_sel  = (state_q == ACC1) ? (raw_q | hi_bytes) : lo_bytes;
`else
  assign raw_sel  = lo_bytes;
`endif

  lsu_load_extend u_load_extend (
    .raw    (raw_sel),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    raw_d       = raw_q;
`endif
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = 32'd0;
    mem_wdata_d = 32'd0;
    mem_be_d    = 4'd0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_bad ? RESP : ACC0;
        end
      end
      ACC0: begin
        state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (cur_cross) begin
          state_d = ACC1;
          raw_d   = lo_bytes;
        end
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Memory strobes are registered for the state being entered, so they are glitch-free.
    if (state_d == ACC0) begin
      mem_read_d  = !cur_we;
      mem_write_d = cur_we;
      mem_addr_d  = word_addr;
      mem_be_d    = lane_be[3:0];
      mem_wdata_d = cur_we ? lane_wd[31:0] : 32'd0;
    end
`ifdef LSU_MISALIGN_SPLIT_EN
    if (state_d == ACC1) begin
      mem_read_d  = !cur_we;
      mem_write_d = cur_we;
      mem_addr_d  = word_addr + 32'd4;
      mem_be_d    = lane_be[7:4];
      mem_wdata_d = cur_we ? lane_wd[63:32] : 32'd0;
    end
`endif

    if (state_d == RESP) begin
      rsp_valid_d = 1'b1;
      if (state_q == IDLE) begin
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b1;
      end else begin
        rsp_rdata_d = we_q ? 32'd0 : ext_data;
        rsp_err_d   = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      raw_q       <= 32'd0;
`endif
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      raw_q       <= raw_d;
`endif
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Self-checking bench for lsu_align_ctrl: byte-level reference model producing a
// per-cycle expected timeline, checked every negedge, plus literal pins of the model.
module tb_lsu_align_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  lsu_align_ctrl #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory seen by the DUT.
  logic [7:0] tb_mem [1024];
  logic [9:0] wbase;
  assign wbase     = {mem_addr[9:2], 2'b00};
  assign mem_rdata = {tb_mem[wbase + 10'd3], tb_mem[wbase + 10'd2],
                      tb_mem[wbase + 10'd1], tb_mem[wbase]};
  always @(posedge clk) begin
    if (mem_write) begin
      for (int l = 0; l < 4; l++)
        if (mem_byte_enable[l]) tb_mem[wbase + 10'(l)] <= mem_wdata[8*l +: 8];
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [1024];

  typedef struct {
    bit        rd;
    bit        wr;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
    bit        rv;
    bit [31:0] rdata;
    bit        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_first, m_second;
  bit [31:0] last_rdata;
  bit        last_err;
  logic [31:0] seen_rdata;
  logic        seen_err;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Derive the cycle-by-cycle behaviour of one transaction from byte-level rules.
  task automatic model_issue(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                             input bit [31:0] wd, output int n);
    int        size;
    int        nw;
    bit        err;
    longint    lastb;
    longint    ba;
    bit [31:0] first;
    bit [31:0] v;
    bit [31:0] rdata;
    exp_t      e;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    err   = (size == 0) || (we && f3[2]);
    lastb = longint'(addr) + longint'(size) - 1;
    if (lastb >= 1024) err = 1'b1;
    if (!SPLIT && size != 0 && (addr % size) != 0) err = 1'b1;
    n = 0;
    v = 32'd0;
    rdata = 32'd0;
    if (!err) begin
      first = addr & ~32'd3;
      nw    = ((addr % 4) + size > 4) ? 2 : 1;
      for (int k = 0; k < nw; k++) begin
        e = '{default: 0};
        e.rd   = !we;
        e.wr   = we;
        e.addr = first + 32'(4 * k);
        for (int lane = 0; lane < 4; lane++) begin
          ba = longint'(e.addr) + longint'(lane);
          if (ba >= longint'(addr) && ba < longint'(addr) + longint'(size)) begin
            e.be[lane] = 1'b1;
            if (we) e.wdata[8*lane +: 8] = wd[8*int'(ba - longint'(addr)) +: 8];
          end
        end
        if (k == 0) m_first = e; else m_second = e;
        exp_q.push_back(e);
        n++;
      end
      for (int i = 0; i < size; i++) begin
        if (we) ref_mem[10'(addr + 32'(i))] = wd[8*i +: 8];
        else    v = v | (32'(ref_mem[10'(addr + 32'(i))]) << (8 * i));
      end
      if (!we) begin
        case (f3)
          3'b000:  rdata = (v >= 32'd128)   ? v - 32'd256   : v;
          3'b001:  rdata = (v >= 32'd32768) ? v - 32'd65536 : v;
          default: rdata = v;
        endcase
      end
    end
    e = '{default: 0};
    e.rv    = 1'b1;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
    n++;
  endtask

  // Compare process: every negedge, DUT outputs against the expected timeline.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_ready", req_ready, 1);
        check("rst_strobes", {mem_read, mem_write, rsp_valid, rsp_err}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", mem_byte_enable, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        last_rdata = 32'd0;
        last_err   = 1'b0;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("busy_ready", req_ready, 0);
        check("mem_read", mem_read, e.rd);
        check("mem_write", mem_write, e.wr);
        check("rsp_valid", rsp_valid, e.rv);
        if (e.rd || e.wr) begin
          check("mem_addr", mem_addr, e.addr);
          check("mem_be", mem_byte_enable, e.be);
        end
        if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
        if (e.rv) begin
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", rsp_err, e.err);
          last_rdata = e.rdata;
          last_err   = e.err;
          seen_rdata = rsp_rdata;
          seen_err   = rsp_err;
        end else begin
          check("hold_rdata", rsp_rdata, last_rdata);
          check("hold_err", rsp_err, last_err);
        end
      end else begin
        check("idle_ready", req_ready, 1);
        check("idle_strobes", {mem_read, mem_write, rsp_valid}, 0);
        check("hold_rdata", rsp_rdata, last_rdata);
        check("hold_err", rsp_err, last_err);
      end
    end
  end

  task automatic wait_drain();
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(posedge clk);
      #2;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic drive(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!req_ready && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    check("ready_wait", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, output int n);
    drive(we, f3, addr, wd);
    model_issue(we, f3, addr, wd, n);
    wait_drain();
  endtask

  // Abandon a store mid-flight with reset; only bytes already committed stay written.
  task automatic reset_abort();
    drive(1'b1, 3'b010, SPLIT ? 32'h2E : 32'h2C, 32'hCAFEF00D);
    if (SPLIT) begin
      @(posedge clk);
      #1;
      ref_mem[10'h2E] = 8'h0D;
      ref_mem[10'h2F] = 8'hF0;
    end
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_ready", req_ready, 1);
    check("abort_strobes", {mem_read, mem_write, rsp_valid, rsp_err}, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_be", mem_byte_enable, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) begin
      tb_mem[i]  = 8'((i * 37 + 5) & 255);
      ref_mem[i] = 8'((i * 37 + 5) & 255);
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Aligned word store/load.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, n);
    check("pin_sw10_be", m_first.be, 4'b1111);
    check("pin_sw10_lat", n, 2);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, n);
    check("lit_lw10", seen_rdata, 32'hDEADBEEF);

    // Byte store into the top lane, signed and unsigned reloads.
    do_req(1'b1, 3'b000, 32'h23, 32'h000000A5, n);
    check("pin_sb23_addr", m_first.addr, 32'h20);
    check("pin_sb23_be", m_first.be, 4'b1000);
    check("pin_sb23_wd", m_first.wdata, 32'hA5000000);
    do_req(1'b0, 3'b000, 32'h23, 32'h0, n);
    check("lit_lb23", seen_rdata, 32'hFFFFFFA5);
    do_req(1'b0, 3'b100, 32'h23, 32'h0, n);
    check("lit_lbu23", seen_rdata, 32'h000000A5);
    do_req(1'b0, 3'b001, 32'h22, 32'h0, n);
    do_req(1'b0, 3'b101, 32'h22, 32'h0, n);
    do_req(1'b1, 3'b001, 32'h42, 32'h00008001, n);
    do_req(1'b0, 3'b001, 32'h42, 32'h0, n);
    check("lit_lh42", seen_rdata, 32'hFFFF8001);

    // Word-crossing accesses.
    do_req(1'b1, 3'b010, 32'h1E, 32'h11223344, n);
    if (SPLIT) begin
      check("pin_sw1e_lat", n, 3);
      check("pin_sw1e_a0", m_first.addr, 32'h1C);
      check("pin_sw1e_be0", m_first.be, 4'b1100);
      check("pin_sw1e_wd0", m_first.wdata, 32'h33440000);
      check("pin_sw1e_a1", m_second.addr, 32'h20);
      check("pin_sw1e_be1", m_second.be, 4'b0011);
      check("pin_sw1e_wd1", m_second.wdata, 32'h00001122);
    end else begin
      check("pin_sw1e_err", seen_err, 1);
    end
    do_req(1'b0, 3'b010, 32'h1E, 32'h0, n);
    if (SPLIT) begin
      check("pin_lw1e_lat", n, 3);
      check("lit_lw1e", seen_rdata, 32'h11223344);
    end
    do_req(1'b0, 3'b001, 32'h1F, 32'h0, n);
    do_req(1'b0, 3'b101, 32'h23, 32'h0, n);
    do_req(1'b0, 3'b001, 32'h05, 32'h0, n);
    check("pin_lh05_lat", n, SPLIT ? 2 : 1);
    check("lit_lh05_err", seen_err, !SPLIT);
    do_req(1'b0, 3'b010, 32'h02, 32'h0, n);
    do_req(1'b0, 3'b000, 32'h03, 32'h0, n);

    // Range edges and illegal encodings.
    do_req(1'b0, 3'b010, 32'h3FE, 32'h0, n);
    check("pin_lw3fe_lat", n, 1);
    check("lit_lw3fe_err", seen_err, 1);
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0, n);
    check("lit_lw3fc_ok", seen_err, 0);
    do_req(1'b0, 3'b000, 32'h3FF, 32'h0, n);
    do_req(1'b0, 3'b001, 32'h3FF, 32'h0, n);
    do_req(1'b1, 3'b001, 32'h3FE, 32'h0000BEEF, n);
    do_req(1'b0, 3'b101, 32'h3FE, 32'h0, n);
    check("lit_lhu3fe", seen_rdata, 32'h0000BEEF);
    do_req(1'b0, 3'b010, 32'h400, 32'h0, n);
    do_req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, n);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, n);
    check("lit_f3_011_err", seen_err, 1);
    do_req(1'b1, 3'b100, 32'h10, 32'h12345678, n);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, n);
    check("lit_lw10_kept", seen_rdata, 32'hDEADBEEF);

    // Reset in the middle of a store, then normal operation.
    reset_abort();
    do_req(1'b0, 3'b010, 32'h2C, 32'h0, n);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, n);
    do_req(1'b1, 3'b010, 32'h50, 32'h0BADCAFE, n);
    do_req(1'b0, 3'b010, 32'h50, 32'h0, n);
    check("lit_after_reset", seen_rdata, 32'h0BADCAFE);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_align_ctrl.md
Name: lsu_align_ctrl

Overview:
- Load/store alignment controller directly upstream of the 1 KB byte-addressed data memory.
- Accepts one load/store request per transaction from the execute stage.
- Drives word-aligned address, shifted write data and byte enables into the memory, then extracts and sign- or zero-extends load data from the memory's combinational read word.
- Sequences misaligned accesses that cross a word boundary into two memory cycles.

Parameters:
- MEM_BYTES, 1024: memory size in bytes. Addresses at or above it are out of range.
- ADDR_W, 32: request address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use 000/001/010 only.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_read  out  1  to memory read enable.
- mem_write  out  1  to memory write enable.
- mem_addr  out  32  word-aligned byte address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-positioned write data.
- mem_byte_enable  out  4  lane enables.
- mem_rdata  in  32  combinational memory read word.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_rdata  out  32  extended load result; 0 for stores.
- rsp_err  out  1  out-of-range, illegal funct3, or (macro off) misaligned.

Behaviour:
- Reset (async, rst_n=0):
  - State → IDLE.
  - All mem_* outputs, rsp_valid, rsp_rdata and rsp_err → 0.
  - req_ready → 1.
  - Reset mid-transaction abandons the transaction; no partial response is issued. A write already clocked into memory stays written.
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE:
    - req_ready=1.
    - On req_valid, latch we/funct3/addr/wdata.
    - Compute size (1/2/4), offset = addr[1:0], and cross = offset+size > 4.
    - Error request (illegal funct3, addr+size-1 ≥ MEM_BYTES, or cross with macro off): go to RESP with err=1 and no memory access.
    - Otherwise go to ACC0.
  - ACC0:
    - Drive word address = addr&~3 and the low lanes.
    - byte_enable = (size mask << offset)[3:0]; wdata = (wdata << 8*offset)[31:0].
    - Loads: mem_read=1, byte_enable informational. Capture the shifted mem_rdata bytes.
    - Go to ACC1 if cross, else RESP.
  - ACC1:
    - Address = (addr&~3)+4.
    - byte_enable = (mask << offset)[7:4]; wdata = (wdata << 8*offset)[63:32].
    - Loads: capture the low bytes of mem_rdata as the upper part of the result.
    - Go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in ACC0/ACC1/RESP.
- mem_read and mem_write are 0 outside ACC0/ACC1. Their outputs are registered from the state, so they are glitch-free.
- Latency from the accept cycle T: aligned or non-crossing → rsp_valid at T+2; crossing → T+3; error → T+1.
- Throughput: one transaction per 3 or 4 cycles; no back-to-back acceptance.
- Load extension:
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: unmodified.
- Stores: rsp_rdata=0. The store is committed at the posedge ending ACC0 (and ACC1 if crossing).
- Wrap-around: a crossing access in the last word of memory is caught by the range check, never wraps to address 0.
- rsp_rdata and rsp_err hold their values until the next RESP.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN
  - Defined: word-crossing accesses are split into ACC0+ACC1 as above.
  - Undefined:
    - Any crossing access, plus halfwords at odd addresses and words at non-zero offsets, is rejected with rsp_err=1 and no memory access.
    - ACC1 is removed from the FSM.

Decomposition:
- Shared package lsu_pkg:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum.
  - Function size_of(funct3).
- One sub-module: lsu_load_extend (combinational byte/half selection plus sign/zero extension from the assembled 32-bit raw value and funct3).

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → ACC0 byte_enable 4'b1111; rsp_rdata 0xDEADBEEF at T+2.
- SB addr 0x23 data 0x000000A5 → mem_addr 0x20, byte_enable 4'b1000, mem_wdata 0xA5000000. LB 0x23 → 0xFFFFFFA5; LBU → 0x000000A5.
- Macro on: SW addr 0x1E data 0x11223344:
  - ACC0: addr 0x1C, be 4'b1100, wdata 0x33440000.
  - ACC1: addr 0x20, be 4'b0011, wdata 0x00001122.
  - LW 0x1E returns 0x11223344 at T+3.
- Macro off: LH addr 0x05 → no mem_read asserted; rsp_err=1 at T+1.
- LW addr 0x3FE (MEM_BYTES=1024) → rsp_err=1, no memory access. Illegal funct3 3'b011 → rsp_err=1.
- Assert rst_n=0 during ACC1 of a split store → outputs zero immediately, state IDLE, no rsp_valid; next request is accepted normally.
